// File: rtl/fifo_level.sv
// fifo_level: single-clock register-file FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a compile-time first-word-fall-through read mode.
module fifo_level #(
  parameter int unsigned WordLength = 8,
  parameter int unsigned AddrBits   = 4,
  parameter int unsigned AfullThr   = 2**AddrBits-2,
  parameter int unsigned AemptyThr  = 2,
  parameter bit          Fwft       = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  wr_i,
  input  logic [WordLength-1:0] w_data_i,
  input  logic                  rd_i,
  output logic [WordLength-1:0] r_data_o,
  output logic                  r_valid_o,
  output logic [AddrBits:0]     count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned Depth = 2**AddrBits;
  localparam int unsigned CntW  = AddrBits + 1;

  typedef logic [AddrBits-1:0]   ptr_t;
  typedef logic [CntW-1:0]       cnt_t;
  typedef logic [WordLength-1:0] word_t;

  localparam cnt_t DepthC  = cnt_t'(Depth);
  localparam cnt_t AfullC  = cnt_t'(AfullThr);
  localparam cnt_t AemptyC = cnt_t'(AemptyThr);

  word_t mem [Depth];
  ptr_t  w_ptr, r_ptr;
  cnt_t  count;
  logic  wr_acc, rd_acc;

  // Status flags come from the count register alone, so they never see
  // a combinational path from the request inputs.
  assign count_o        = count;
  assign empty_o        = (count == '0);
  assign full_o         = (count == DepthC);
  assign almost_empty_o = (count <= AemptyC);
  assign almost_full_o  = (count >= AfullC);

  // Accept decisions use the registered full/empty state, so a read can
  // never make room for a write (or a write supply a read) in one cycle.
  assign wr_acc = wr_i & ~full_o  & ~flush_i;
  assign rd_acc = rd_i & ~empty_o & ~flush_i;

  // Pointer and occupancy state; flush wins over any request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + ptr_t'(1);
      if (rd_acc) r_ptr <= r_ptr + ptr_t'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset; writes are blocked while reset is held so a
  // reset pulse cannot leave a half-committed word behind.
  always_ff @(posedge clk_i) begin
    if (wr_acc && rst_ni) mem[w_ptr] <= w_data_i;
  end

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_i && full_o)  overflow_o  <= 1'b1;
      if (rd_i && empty_o) underflow_o <= 1'b1;
    end
  end

  generate
    if (Fwft) begin : g_fwft
      // Head word is presented directly; a read acknowledges and pops it.
      assign r_data_o  = mem[r_ptr];
      assign r_valid_o = ~empty_o;
    end else begin : g_std
      word_t r_data_q;
      logic  r_valid_q;

      // Registered read: data lands one cycle after an accepted read and
      // holds afterwards; valid is a single-cycle pulse.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_data_q  <= '0;
          r_valid_q <= 1'b0;
        end else if (flush_i) begin
          r_valid_q <= 1'b0;
        end else begin
          r_valid_q <= rd_acc;
          if (rd_acc) r_data_q <= mem[r_ptr];
        end
      end

      assign r_data_o  = r_data_q;
      assign r_valid_o = r_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: drives a standard-read and a FWFT instance with the same
// directed stimulus; a queue-based model is checked every cycle and a set
// of hand-computed literals pins the model.
module tb_fifo_level;

  localparam int D = 16;

  logic       clk, rst_n, flush, wr, rd;
  logic [7:0] wd;

  logic [7:0] rdata0, rdata1;
  logic       rv0, rv1;
  logic [4:0] cnt0, cnt1;
  logic       emp0, emp1, ful0, ful1, ae0, ae1, af0, af1, ov0, ov1, un0, un1;

  int nvec = 0;
  int nerr = 0;

  // Reference model: a plain queue plus the externally visible flags.
  logic [7:0] q [$];
  logic       m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  fifo_level #(.WordLength(8), .AddrBits(4), .AfullThr(14), .AemptyThr(2), .Fwft(1'b0)) u_std (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_i(wr), .w_data_i(wd), .rd_i(rd),
    .r_data_o(rdata0), .r_valid_o(rv0), .count_o(cnt0), .empty_o(emp0), .full_o(ful0),
    .almost_empty_o(ae0), .almost_full_o(af0), .overflow_o(ov0), .underflow_o(un0));

  fifo_level #(.WordLength(8), .AddrBits(4), .AfullThr(14), .AemptyThr(2), .Fwft(1'b1)) u_fwft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_i(wr), .w_data_i(wd), .rd_i(rd),
    .r_data_o(rdata1), .r_valid_o(rv1), .count_o(cnt1), .empty_o(emp1), .full_o(ful1),
    .almost_empty_o(ae1), .almost_full_o(af1), .overflow_o(ov1), .underflow_o(un1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = 8'h00;
  endtask

  // One clock edge of the model, from the inputs applied during the cycle.
  task automatic m_step();
    bit was_full, was_empty;
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    if (flush) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (wr && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_unf = 1'b1;
      if (rd && !was_empty) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (wr && !was_full) q.push_back(wd);
    end
  endtask

  task automatic chk_common(input string tag, input logic [4:0] c, input logic e, input logic f,
                            input logic ae, input logic af, input logic ov, input logic un);
    int n;
    n = q.size();
    chk({tag, " count"}, 32'(c), 32'(n));
    chk({tag, " empty"}, 32'(e), 32'(n == 0));
    chk({tag, " full"}, 32'(f), 32'(n == D));
    chk({tag, " almost_empty"}, 32'(ae), 32'(n <= 2));
    chk({tag, " almost_full"}, 32'(af), 32'(n >= 14));
    chk({tag, " overflow"}, 32'(ov), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(un), 32'(m_unf));
  endtask

  // Mid-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk_common("std", cnt0, emp0, ful0, ae0, af0, ov0, un0);
    chk_common("fwft", cnt1, emp1, ful1, ae1, af1, ov1, un1);
    chk("std r_valid", 32'(rv0), 32'(m_rv));
    chk("std r_data", 32'(rdata0), 32'(m_rd));
    chk("fwft r_valid", 32'(rv1), 32'(q.size() != 0));
    if (q.size() != 0) chk("fwft r_data", 32'(rdata1), 32'(q[0]));
  end

  // Apply one cycle of inputs, advance model at the edge, return at edge+1.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
    wr = w; wd = d; rd = r; flush = f;
    @(posedge clk);
    m_step();
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
  endtask

  initial begin
    wr = 1'b0; rd = 1'b0; flush = 1'b0; wd = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst count", 32'(cnt0), 0);
    chk("rst empty", 32'(emp0), 1);
    chk("rst almost_empty", 32'(ae0), 1);
    chk("rst full", 32'(ful0), 0);
    chk("rst almost_full", 32'(af0), 0);
    chk("rst flags", {30'd0, ov0, un0}, 0);
    chk("rst std r_valid", 32'(rv0), 0);
    chk("rst std r_data", 32'(rdata0), 0);
    chk("rst fwft r_valid", 32'(rv1), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill count", 32'(cnt0), 32'(i));
      if (i == 1)  chk("fwft first word", {23'd0, rv1, rdata1}, 32'h101);
      if (i == 2)  chk("fill ae@2", 32'(ae0), 1);
      if (i == 3)  chk("fill ae@3", 32'(ae0), 0);
      if (i == 13) chk("fill af@13", 32'(af0), 0);
      if (i == 14) chk("fill af@14", 32'(af0), 1);
      if (i == 15) chk("fill full@15", 32'(ful0), 0);
      if (i == 16) chk("fill full@16", 32'(ful0), 1);
    end
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("17th write overflow", 32'(ov0), 1);
    chk("17th write count", 32'(cnt0), 16);

    // Drain 16 words in order.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain r_valid", 32'(rv0), 1);
      chk("drain r_data", 32'(rdata0), 32'(i));
      if (i < 16) chk("drain fwft head", 32'(rdata1), 32'(i + 1));
    end
    chk("drain empty", 32'(emp0), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underflow set", 32'(un0), 1);
    chk("underflow r_valid", 32'(rv0), 0);
    chk("underflow r_data hold", 32'(rdata0), 32'h10);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush clears flags", {30'd0, ov0, un0}, 0);

    // Steady rd&wr at count 5 across several pointer wraps.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 8'(8'h25 + k), 1'b1, 1'b0);
      chk("rw5 count", 32'(cnt0), 5);
      chk("rw5 order", {23'd0, rv0, rdata0}, 32'h100 + 32'(8'h20 + k));
    end

    // rd&wr at full: read taken, write dropped.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    chk("rw full count", 32'(cnt0), 15);
    chk("rw full overflow", 32'(ov0), 1);
    chk("rw full data", {23'd0, rv0, rdata0}, 32'h140);
    chk("rw full fwft head", 32'(rdata1), 32'h41);

    // rd&wr at empty: write taken, no pop.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("rw empty count", 32'(cnt0), 1);
    chk("rw empty underflow", 32'(un0), 1);
    chk("rw empty no pop", 32'(rv0), 0);
    chk("rw empty fwft head", {23'd0, rv1, rdata1}, 32'h177);

    // FWFT visibility and pop.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("fwft 5A visible", {23'd0, rv1, rdata1}, 32'h15A);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft pop r_valid", 32'(rv1), 0);
    chk("std 5A read", {23'd0, rv0, rdata0}, 32'h15A);

    // Flush at count 9 with both error flags set and a write pending.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAB, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre-flush count", 32'(cnt0), 9);
    chk("pre-flush flags", {30'd0, ov0, un0}, 3);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("flush count", 32'(cnt0), 0);
    chk("flush empty", 32'(emp0), 1);
    chk("flush flags", {30'd0, ov0, un0}, 0);
    chk("flush r_valid", 32'(rv0), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush write dropped", 32'(cnt1), 0);

    // Asynchronous reset between edges at count 7.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("pre-reset count", 32'(cnt0), 7);
    #3 rst_n = 1'b0;
    m_reset();
    #1;
    chk("async rst count", 32'(cnt0), 0);
    chk("async rst empty", {30'd0, emp0, ae0}, 3);
    chk("async rst full", {30'd0, ful0, af0}, 0);
    chk("async rst std", {23'd0, rv0, rdata0}, 0);
    chk("async rst fwft valid", 32'(rv1), 0);
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post-reset read", {23'd0, rv0, rdata0}, 32'h100 + 32'(8'hC0 + i));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post-reset empty", 32'(emp0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
